// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: decoder strobes in, datapath enables out, for the 6502
// cycle sequencer. The sequencer itself uses the master modport, and the
// datapath side uses the slave modport.
// When SEQ_RDY_EN is defined, the memory-ready input rdy is added.
interface cpu_sequencer_if #(
    parameter int ADR_W = 5
);
    logic [ADR_W-1:0] adr_mode;
    logic             from_mem;
    logic             to_mem;
    logic             branch_cond;
    logic             page_cross;
`ifdef SEQ_RDY_EN
    logic             rdy;
`endif
    logic             sync;
    logic             ir_load;
    logic             pc_inc;
    logic [1:0]       adr_src;
    logic             adl_load;
    logic             adh_load;
    logic             idx_add;
    logic             adh_fix;
    logic             mem_rd;
    logic             mem_we;
    logic             alu_exec;
    logic             pc_rel;
    logic             halted;
    logic [2:0]       tstate;

    modport master (
`ifdef SEQ_RDY_EN
        input  rdy,
`endif
        input  adr_mode, from_mem, to_mem, branch_cond, page_cross,
        output sync, ir_load, pc_inc, adr_src, adl_load, adh_load, idx_add,
        output adh_fix, mem_rd, mem_we, alu_exec, pc_rel, halted, tstate
    );

    modport slave (
`ifdef SEQ_RDY_EN
        output rdy,
`endif
        output adr_mode, from_mem, to_mem, branch_cond, page_cross,
        input  sync, ir_load, pc_inc, adr_src, adl_load, adh_load, idx_add,
        input  adh_fix, mem_rd, mem_we, alu_exec, pc_rel, halted, tstate
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: T-state sequencer for the 6502 core.
// State-only enables are registered. The DECODE-cycle strobes depend on the
// addressing mode that has just been loaded into IR, so they are combinational.
// For indexed absolute modes, the index add overlaps the ADH fetch in ABSL.
// page_cross is then resolved at the end of ABSL: a crossing costs one FIX cycle.
// A zero-page store skips the dummy ZP cycle and goes straight to WR1.
// Optional feature macro SEQ_RDY_EN: adds rdy. Read cycles with rdy=0 stall
// and gate the load/increment strobes.
module cpu_sequencer #(
    parameter int ADR_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_sequencer_if.master bus
);
    localparam logic [ADR_W-1:0] ADR_IMPL      = ADR_W'(0);
    localparam logic [ADR_W-1:0] ADR_ACCUM     = ADR_W'(1);
    localparam logic [ADR_W-1:0] ADR_IMM       = ADR_W'(2);
    localparam logic [ADR_W-1:0] ADR_ZPG       = ADR_W'(3);
    localparam logic [ADR_W-1:0] ADR_ZPG_RMW   = ADR_W'(4);
    localparam logic [ADR_W-1:0] ADR_ZPG_X_Y   = ADR_W'(5);
    localparam logic [ADR_W-1:0] ADR_ZPG_X_RMW = ADR_W'(6);
    localparam logic [ADR_W-1:0] ADR_ABS       = ADR_W'(7);
    localparam logic [ADR_W-1:0] ADR_ABS_RMW   = ADR_W'(8);
    localparam logic [ADR_W-1:0] ADR_ABS_X_Y   = ADR_W'(9);
    localparam logic [ADR_W-1:0] ADR_ABS_X_RMW = ADR_W'(10);
    localparam logic [ADR_W-1:0] ADR_REL       = ADR_W'(11);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_ZP, S_ABSL, S_IDX, S_FIX, S_READ,
        S_MOD, S_WR1, S_WR2, S_BR_TAKE, S_BR_FIX, S_HALT
    } state_t;

    state_t     state, state_nx;
    logic [2:0] tstate, tstate_nx;
    logic       zp, zp_nx, rmw, rmw_nx, idx, idx_nx;
    logic       store, stall;
    logic       dec_pc_inc, dec_adl_load, dec_alu_exec;
    logic       sync_r, ir_load_r, pc_inc_r, adh_load_r, idx_add_r, adh_fix_r;
    logic       mem_rd_r, mem_we_r, alu_exec_r, pc_rel_r, halted_r;
    logic [1:0] adr_src_r;
    logic       sync_nx, ir_load_nx, pc_inc_nx, adh_load_nx, idx_add_nx, adh_fix_nx;
    logic       mem_rd_nx, mem_we_nx, alu_exec_nx, pc_rel_nx, halted_nx;
    logic [1:0] adr_src_nx, ea_nx;

`ifdef SEQ_RDY_EN
    assign stall = mem_rd_r & ~bus.rdy;
`else
    assign stall = 1'b0;
`endif

    // Pure stores write without a prior read; RMW instructions set both strobes
    assign store = bus.to_mem & ~bus.from_mem;

    // Next-state, tstate, mode flags, and DECODE-cycle strobes
    always_comb begin
        state_nx     = state;
        zp_nx        = zp;
        rmw_nx       = rmw;
        idx_nx       = idx;
        dec_pc_inc   = 1'b0;
        dec_adl_load = 1'b0;
        dec_alu_exec = 1'b0;
        case (state)
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: begin
                zp_nx  = 1'b0;
                rmw_nx = 1'b0;
                idx_nx = 1'b0;
                case (bus.adr_mode)
                    ADR_IMPL, ADR_ACCUM: begin
                        dec_alu_exec = 1'b1;
                        state_nx     = S_FETCH;
                    end
                    ADR_IMM: begin
                        dec_pc_inc   = 1'b1;
                        dec_alu_exec = 1'b1;
                        state_nx     = S_FETCH;
                    end
                    ADR_ZPG, ADR_ZPG_RMW: begin
                        dec_adl_load = 1'b1;
                        dec_pc_inc   = 1'b1;
                        zp_nx        = 1'b1;
                        rmw_nx       = (bus.adr_mode == ADR_ZPG_RMW);
                        state_nx     = store ? S_WR1 : S_ZP;
                    end
                    ADR_ZPG_X_Y, ADR_ZPG_X_RMW: begin
                        dec_adl_load = 1'b1;
                        dec_pc_inc   = 1'b1;
                        zp_nx        = 1'b1;
                        rmw_nx       = (bus.adr_mode == ADR_ZPG_X_RMW);
                        state_nx     = S_IDX;
                    end
                    ADR_ABS, ADR_ABS_RMW, ADR_ABS_X_Y, ADR_ABS_X_RMW: begin
                        dec_adl_load = 1'b1;
                        dec_pc_inc   = 1'b1;
                        rmw_nx       = (bus.adr_mode == ADR_ABS_RMW) ||
                                       (bus.adr_mode == ADR_ABS_X_RMW);
                        idx_nx       = (bus.adr_mode == ADR_ABS_X_Y) ||
                                       (bus.adr_mode == ADR_ABS_X_RMW);
                        state_nx     = S_ABSL;
                    end
                    ADR_REL: begin
                        dec_pc_inc = 1'b1;
                        state_nx   = bus.branch_cond ? S_BR_TAKE : S_FETCH;
                    end
                    default:  state_nx = S_HALT;
                endcase
            end
            S_ABSL: begin
                if (idx)
                    state_nx = (bus.page_cross || bus.to_mem || rmw) ? S_FIX : S_READ;
                else
                    state_nx = store ? S_WR1 : S_READ;
            end
            S_IDX, S_FIX:    state_nx = store ? S_WR1 : S_READ;
            S_ZP, S_READ:    state_nx = rmw ? S_MOD : S_FETCH;
            S_MOD:           state_nx = S_WR2;
            S_WR1, S_WR2:    state_nx = S_FETCH;
            S_BR_TAKE:       state_nx = bus.page_cross ? S_BR_FIX : S_FETCH;
            S_BR_FIX:        state_nx = S_FETCH;
            S_HALT:          state_nx = S_HALT;
            default:         state_nx = S_FETCH;
        endcase
        if (stall) begin
            state_nx = state;
            zp_nx    = zp;
            rmw_nx   = rmw;
            idx_nx   = idx;
        end
        if (state_nx == S_FETCH)
            tstate_nx = 3'd0;
        else if (state_nx != state)
            tstate_nx = tstate + 3'd1;
        else
            tstate_nx = tstate;
    end

    // Moore enables of the state being entered, registered at the next edge
    always_comb begin
        ea_nx       = zp_nx ? 2'd1 : 2'd2;
        sync_nx     = 1'b0;
        ir_load_nx  = 1'b0;
        pc_inc_nx   = 1'b0;
        adr_src_nx  = 2'd0;
        adh_load_nx = 1'b0;
        idx_add_nx  = 1'b0;
        adh_fix_nx  = 1'b0;
        mem_rd_nx   = 1'b0;
        mem_we_nx   = 1'b0;
        alu_exec_nx = 1'b0;
        pc_rel_nx   = 1'b0;
        halted_nx   = 1'b0;
        case (state_nx)
            S_FETCH:   begin sync_nx = 1'b1; ir_load_nx = 1'b1; pc_inc_nx = 1'b1; mem_rd_nx = 1'b1; end
            S_DECODE:  mem_rd_nx = 1'b1;
            S_ZP:      begin mem_rd_nx = 1'b1; adr_src_nx = 2'd1; alu_exec_nx = ~rmw_nx; end
            S_ABSL:    begin adh_load_nx = 1'b1; pc_inc_nx = 1'b1; mem_rd_nx = 1'b1; idx_add_nx = idx_nx; end
            S_IDX:     begin idx_add_nx = 1'b1; adr_src_nx = 2'd1; mem_rd_nx = 1'b1; end
            S_FIX:     begin adh_fix_nx = 1'b1; adr_src_nx = 2'd2; mem_rd_nx = 1'b1; end
            S_READ:    begin mem_rd_nx = 1'b1; adr_src_nx = ea_nx; alu_exec_nx = ~rmw_nx; end
            S_MOD:     begin mem_we_nx = 1'b1; adr_src_nx = ea_nx; end
            S_WR1:     begin mem_we_nx = 1'b1; adr_src_nx = ea_nx; end
            S_WR2:     begin mem_we_nx = 1'b1; adr_src_nx = ea_nx; alu_exec_nx = 1'b1; end
            S_BR_TAKE: begin pc_rel_nx = 1'b1; mem_rd_nx = 1'b1; end
            S_BR_FIX:  begin adh_fix_nx = 1'b1; mem_rd_nx = 1'b1; end
            S_HALT:    halted_nx = 1'b1;
            default:   ;
        endcase
    end

    // Sequencer FSM: state, T-state counter, mode flags and registered enables
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            tstate     <= 3'd0;
            zp         <= 1'b0;
            rmw        <= 1'b0;
            idx        <= 1'b0;
            sync_r     <= 1'b1;
            ir_load_r  <= 1'b1;
            pc_inc_r   <= 1'b1;
            adr_src_r  <= 2'd0;
            adh_load_r <= 1'b0;
            idx_add_r  <= 1'b0;
            adh_fix_r  <= 1'b0;
            mem_rd_r   <= 1'b1;
            mem_we_r   <= 1'b0;
            alu_exec_r <= 1'b0;
            pc_rel_r   <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state      <= state_nx;
            tstate     <= tstate_nx;
            zp         <= zp_nx;
            rmw        <= rmw_nx;
            idx        <= idx_nx;
            sync_r     <= sync_nx;
            ir_load_r  <= ir_load_nx;
            pc_inc_r   <= pc_inc_nx;
            adr_src_r  <= adr_src_nx;
            adh_load_r <= adh_load_nx;
            idx_add_r  <= idx_add_nx;
            adh_fix_r  <= adh_fix_nx;
            mem_rd_r   <= mem_rd_nx;
            mem_we_r   <= mem_we_nx;
            alu_exec_r <= alu_exec_nx;
            pc_rel_r   <= pc_rel_nx;
            halted_r   <= halted_nx;
        end
    end

    assign bus.sync     = sync_r;
    assign bus.ir_load  = ir_load_r & ~stall;
    assign bus.pc_inc   = (pc_inc_r | dec_pc_inc) & ~stall;
    assign bus.adr_src  = adr_src_r;
    assign bus.adl_load = dec_adl_load & ~stall;
    assign bus.adh_load = adh_load_r & ~stall;
    assign bus.idx_add  = idx_add_r;
    assign bus.adh_fix  = adh_fix_r;
    assign bus.mem_rd   = mem_rd_r;
    assign bus.mem_we   = mem_we_r;
    assign bus.alu_exec = (alu_exec_r | dec_alu_exec) & ~stall;
    assign bus.pc_rel   = pc_rel_r;
    assign bus.halted   = halted_r;
    assign bus.tstate   = tstate;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed cycle-by-cycle checks of the 6502 sequencer.
// Each observation packs all outputs into one 17-bit word, compared against
// hand-written per-cycle expectations.
module tb_cpu_sequencer;
    localparam logic [4:0] ADR_IMPL      = 5'd0;
    localparam logic [4:0] ADR_IMM       = 5'd2;
    localparam logic [4:0] ADR_ZPG_RMW   = 5'd4;
    localparam logic [4:0] ADR_ZPG_X_Y   = 5'd5;
    localparam logic [4:0] ADR_ABS       = 5'd7;
    localparam logic [4:0] ADR_ABS_X_Y   = 5'd9;
    localparam logic [4:0] ADR_ABS_X_RMW = 5'd10;
    localparam logic [4:0] ADR_REL       = 5'd11;
    localparam logic [4:0] ADR_INVAL     = 5'd31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [16:0] got [0:15];
    logic [16:0] exp [0:15];

    cpu_sequencer_if #(.ADR_W(5)) bus ();
    cpu_sequencer #(.ADR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // {sync, ir_load, pc_inc, adr_src, adl_load, adh_load, idx_add, adh_fix,
    //  mem_rd, mem_we, alu_exec, pc_rel, halted, tstate}
    function automatic logic [16:0] pk(int sy, int ir, int pc, int src, int adl, int adh,
                                       int idx, int fix, int rd, int we, int alu,
                                       int rel, int hlt, int ts);
        return {1'(sy), 1'(ir), 1'(pc), 2'(src), 1'(adl), 1'(adh), 1'(idx), 1'(fix),
                1'(rd), 1'(we), 1'(alu), 1'(rel), 1'(hlt), 3'(ts)};
    endfunction

    function automatic logic [16:0] fetchv();
        return pk(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [16:0] obs();
        return {bus.sync, bus.ir_load, bus.pc_inc, bus.adr_src, bus.adl_load, bus.adh_load,
                bus.idx_add, bus.adh_fix, bus.mem_rd, bus.mem_we, bus.alu_exec, bus.pc_rel,
                bus.halted, bus.tstate};
    endfunction

    task automatic set_inputs(input logic [4:0] mode, input logic fm, input logic tm,
                              input logic bc, input logic pcx);
        bus.adr_mode    = mode;
        bus.from_mem    = fm;
        bus.to_mem      = tm;
        bus.branch_cond = bc;
        bus.page_cross  = pcx;
    endtask

    // Record n consecutive cycles; stays in the last recorded cycle
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            #1 got[i] = obs();
            if (i < n - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        set_inputs(ADR_INVAL, 1'b1, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            #1 checks++;
            if (obs() !== fetchv()) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b expected %b", i, obs(), fetchv());
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_nop();
        set_inputs(ADR_IMPL, 1'b0, 1'b0, 1'b0, 1'b0);
        exp[0] = fetchv();
        exp[1] = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
        exp[2] = fetchv();
        capture(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL nop cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_abs_indexed();
        // LDA $1234,X without page cross
        set_inputs(ADR_ABS_X_Y, 1'b1, 1'b0, 1'b0, 1'b0);
        exp[0] = fetchv();
        exp[1] = pk(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        exp[2] = pk(0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 2);
        exp[3] = pk(0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 3);
        exp[4] = fetchv();
        capture(5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL lda_absx_nocross cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
        // LDA $12F8,X crossing into the next page
        set_inputs(ADR_ABS_X_Y, 1'b1, 1'b0, 1'b0, 1'b1);
        exp[3] = pk(0, 0, 0, 2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3);
        exp[4] = pk(0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 4);
        exp[5] = fetchv();
        capture(6);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL lda_absx_cross cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
        // STA $1234,X always takes the fixup cycle
        set_inputs(ADR_ABS_X_Y, 1'b0, 1'b1, 1'b0, 1'b0);
        exp[4] = pk(0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4);
        capture(6);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL sta_absx cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_zp_rmw();
        set_inputs(ADR_ZPG_RMW, 1'b1, 1'b1, 1'b0, 1'b0);
        exp[0] = fetchv();
        exp[1] = pk(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        exp[2] = pk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2);
        exp[3] = pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3);
        exp[4] = pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4);
        exp[5] = fetchv();
        capture(6);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL inc_zp cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_branch();
        exp[0] = fetchv();
        exp[1] = pk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        exp[2] = fetchv();
        set_inputs(ADR_REL, 1'b0, 1'b0, 1'b0, 1'b1);
        capture(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL bne_not_taken cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
        exp[2] = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2);
        exp[3] = fetchv();
        set_inputs(ADR_REL, 1'b0, 1'b0, 1'b1, 1'b0);
        capture(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL bne_taken cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
        exp[3] = pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3);
        exp[4] = fetchv();
        set_inputs(ADR_REL, 1'b0, 1'b0, 1'b1, 1'b1);
        capture(5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL bne_taken_cross cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_halt();
        set_inputs(ADR_INVAL, 1'b0, 1'b0, 1'b0, 1'b0);
        exp[0] = fetchv();
        exp[1] = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        exp[2] = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        exp[3] = exp[2];
        capture(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL halt cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
        rst_n = 1'b0;
        @(posedge clk);
        #2 checks++;
        if (obs() !== fetchv()) begin
            errors++;
            $display("FAIL halt_reset: got %b expected %b", obs(), fetchv());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_rmw();
        set_inputs(ADR_ZPG_RMW, 1'b1, 1'b1, 1'b0, 1'b0);
        exp[0] = fetchv();
        exp[1] = pk(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        exp[2] = pk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2);
        exp[3] = pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3);
        capture(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL rmw_abort cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
        rst_n = 1'b0;
        @(posedge clk);
        #2 checks++;
        if (obs() !== fetchv()) begin
            errors++;
            $display("FAIL rmw_abort_reset: got %b expected %b", obs(), fetchv());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        // LDA $40,X
        set_inputs(ADR_ZPG_X_Y, 1'b1, 1'b0, 1'b0, 1'b0);
        exp[0] = fetchv();
        exp[1] = pk(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        exp[2] = pk(0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2);
        exp[3] = pk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 3);
        exp[4] = fetchv();
        capture(5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL lda_zpx cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
        // LDA #imm
        set_inputs(ADR_IMM, 1'b0, 1'b0, 1'b0, 1'b0);
        exp[1] = pk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
        exp[2] = fetchv();
        capture(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL lda_imm cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
        // INC $1234,X: 7 cycles
        set_inputs(ADR_ABS_X_RMW, 1'b1, 1'b1, 1'b0, 1'b0);
        exp[1] = pk(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        exp[2] = pk(0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 2);
        exp[3] = pk(0, 0, 0, 2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3);
        exp[4] = pk(0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4);
        exp[5] = pk(0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5);
        exp[6] = pk(0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6);
        exp[7] = fetchv();
        capture(8);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL inc_absx cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
    endtask

`ifdef SEQ_RDY_EN
    task automatic test_rdy();
        logic [16:0] stalled;
        set_inputs(ADR_ABS, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.rdy = 1'b1;
        exp[0] = fetchv();
        exp[1] = pk(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        exp[2] = pk(0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2);
        capture(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL rdy_pre cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
        stalled = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2);
        bus.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 checks++;
            if (obs() !== stalled) begin
                errors++;
                $display("FAIL rdy_stall cycle %0d: got %b expected %b", i, obs(), stalled);
            end
            @(posedge clk);
            #1;
        end
        bus.rdy = 1'b1;
        exp[0] = pk(0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2);
        exp[1] = pk(0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 3);
        exp[2] = fetchv();
        capture(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL rdy_resume cycle %0d: got %b expected %b", i, got[i], exp[i]);
            end
        end
    endtask
`endif

    initial begin
`ifdef SEQ_RDY_EN
        bus.rdy = 1'b1;
`endif
        test_reset();
        test_nop();
        test_abs_indexed();
        test_zp_rmw();
        test_branch();
        test_halt();
        test_reset_mid_rmw();
        test_back_to_back();
`ifdef SEQ_RDY_EN
        test_rdy();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
